// File: rtl/stream_resize_pkg.sv
// Shared constants and helpers for the stream width converters.
// Provides the selection direction encoding and index-width helper.
package stream_resize_pkg;

    localparam logic DIR_LSB = 1'b0;
    localparam logic DIR_MSB = 1'b1;

    function automatic int unsigned idx_width(int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/stream_ffs.sv
// Parametrised find-first-set with selectable scan direction.
// Returns the index and one-hot of the first set bit.
module stream_ffs
    import stream_resize_pkg::*;
#(
    parameter int unsigned WIDTH = 4,
    localparam int unsigned IW = idx_width(WIDTH)
) (
    input  logic [WIDTH-1:0] vec_i,
    input  logic             dir_i,
    output logic [IW-1:0]    idx_o,
    output logic [WIDTH-1:0] onehot_o,
    output logic             found_o
);

    logic [IW-1:0] pos;

    always_comb begin
        idx_o    = '0;
        onehot_o = '0;
        found_o  = 1'b0;
        pos      = '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            pos = (dir_i == DIR_MSB) ? IW'(WIDTH - 1 - i) : IW'(i);
            if (!found_o && vec_i[pos]) begin
                found_o       = 1'b1;
                idx_o         = pos;
                onehot_o[pos] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/stream_downsize_keep.sv
// Splits a wide beat into narrow words, skipping words whose keep bit is clear.
// An all-empty last beat becomes a single null terminator word.
module stream_downsize_keep
    import stream_resize_pkg::*;
#(
    parameter int unsigned T_DATA_WIDTH = 8,
    parameter int unsigned T_DATA_RATIO = 4,
    parameter bit          LSB_FIRST    = 1'b1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [T_DATA_WIDTH-1:0] s_data_i [T_DATA_RATIO],
    input  logic [T_DATA_RATIO-1:0] s_keep_i,
    input  logic                    s_last_i,
    input  logic                    s_valid_i,
    output logic                    s_ready_o,
    output logic [T_DATA_WIDTH-1:0] m_data_o,
    output logic                    m_keep_o,
    output logic                    m_last_o,
    output logic                    m_valid_o,
    input  logic                    m_ready_i
);

    localparam int unsigned IW = idx_width(T_DATA_RATIO);
    localparam int unsigned R  = T_DATA_RATIO;

    logic [T_DATA_WIDTH-1:0] data_q [R];
    logic [T_DATA_WIDTH-1:0] data_d [R];
    logic [R-1:0]            mask_q, mask_d;
    logic                    last_q, last_d;
    logic                    valid_q, valid_d;

    logic [IW-1:0] sel_idx;
    logic [R-1:0]  sel_oh;
    logic          sel_found;
    logic          final_word;
    logic          accept;
    logic          xfer;

    stream_ffs #(
        .WIDTH(R)
    ) u_ffs (
        .vec_i   (mask_q),
        .dir_i   (LSB_FIRST ? DIR_LSB : DIR_MSB),
        .idx_o   (sel_idx),
        .onehot_o(sel_oh),
        .found_o (sel_found)
    );

    // A null word (empty mask) is also the final word of its beat.
    assign final_word = valid_q && ((mask_q & (mask_q - R'(1))) == '0);
    assign xfer       = valid_q && m_ready_i;
    assign s_ready_o  = !valid_q || (final_word && m_ready_i);
    assign accept     = s_valid_i && s_ready_o;

    assign m_valid_o = valid_q;
    assign m_keep_o  = sel_found;
    assign m_data_o  = sel_found ? data_q[sel_idx] : '0;
    assign m_last_o  = valid_q && last_q && final_word;

    always_comb begin
        data_d  = data_q;
        mask_d  = mask_q;
        last_d  = last_q;
        valid_d = valid_q;
        if (xfer) begin
            mask_d = mask_q & ~sel_oh;
            if (mask_d == '0) begin
                valid_d = 1'b0;
            end
        end
        if (accept) begin
            if (s_keep_i != '0) begin
                data_d  = s_data_i;
                mask_d  = s_keep_i;
                last_d  = s_last_i;
                valid_d = 1'b1;
            end else if (s_last_i) begin
                mask_d  = '0;
                last_d  = 1'b1;
                valid_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mask_q  <= '0;
            last_q  <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            mask_q  <= mask_d;
            last_q  <= last_d;
            valid_q <= valid_d;
        end
    end

    always_ff @(posedge clk) begin
        data_q <= data_d;
    end

endmodule

// File: tb/tb_stream_downsize_keep.sv
// Directed and randomized checks of stream_downsize_keep against a queue model.
// Covers both emission orders, null terminators, stalls and mid-beat reset.
module tb_stream_downsize_keep;

    localparam int W = 8;
    localparam int R = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic [W-1:0] s_data [R];
    logic [R-1:0] s_keep;
    logic         s_last;
    logic         s_valid;
    logic         s_ready;
    logic [W-1:0] m_data;
    logic         m_keep;
    logic         m_last;
    logic         m_valid;
    logic         m_ready;

    logic [W-1:0] s_data_m [R];
    logic [R-1:0] s_keep_m;
    logic         s_last_m;
    logic         s_valid_m;
    logic         s_ready_m;
    logic [W-1:0] m_data_m;
    logic         m_keep_m;
    logic         m_last_m;
    logic         m_valid_m;
    logic         m_ready_m;

    int tests = 0;
    int fails = 0;
    logic stall_en = 1'b0;
    logic [W+1:0] exp_q [$];

    always #5 clk = ~clk;

    stream_downsize_keep #(
        .T_DATA_WIDTH(W),
        .T_DATA_RATIO(R),
        .LSB_FIRST   (1'b1)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .s_data_i (s_data),
        .s_keep_i (s_keep),
        .s_last_i (s_last),
        .s_valid_i(s_valid),
        .s_ready_o(s_ready),
        .m_data_o (m_data),
        .m_keep_o (m_keep),
        .m_last_o (m_last),
        .m_valid_o(m_valid),
        .m_ready_i(m_ready)
    );

    stream_downsize_keep #(
        .T_DATA_WIDTH(W),
        .T_DATA_RATIO(R),
        .LSB_FIRST   (1'b0)
    ) dut_m (
        .clk      (clk),
        .rst      (rst),
        .s_data_i (s_data_m),
        .s_keep_i (s_keep_m),
        .s_last_i (s_last_m),
        .s_valid_i(s_valid_m),
        .s_ready_o(s_ready_m),
        .m_data_o (m_data_m),
        .m_keep_o (m_keep_m),
        .m_last_o (m_last_m),
        .m_valid_o(m_valid_m),
        .m_ready_i(m_ready_m)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Expected words of one beat: kept words in emission order,
    // last flag on the final kept word, or a lone null word.
    task automatic push_beat(input logic [W-1:0] d [R], input logic [R-1:0] k,
                             input logic l);
        int cnt;
        int n;
        int idx;
        cnt = $countones(k);
        n = 0;
        for (int p = 0; p < R; p++) begin
            idx = p;
            if (k[idx]) begin
                n++;
                exp_q.push_back({d[idx], 1'b1, l && (n == cnt)});
            end
        end
        if (cnt == 0 && l) exp_q.push_back({{W{1'b0}}, 1'b0, 1'b1});
    endtask

    task automatic send(input logic [W-1:0] d [R], input logic [R-1:0] k,
                        input logic l);
        int n;
        s_data  = d;
        s_keep  = k;
        s_last  = l;
        s_valid = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!s_ready && n < 200);
        if (!s_ready) chk("accept_timeout", {31'd0, s_ready}, 32'd1);
        else push_beat(d, k, l);
        @(posedge clk);
        #1;
    endtask

    logic [W-1:0] d [R];
    logic [W-1:0] e [R];
    logic         p_stall;
    logic [W+1:0] p_word;
    logic [W+1:0] ew;
    int           n;

    initial begin
        rst       = 1'b1;
        s_valid   = 1'b0;
        s_keep    = '0;
        s_last    = 1'b0;
        s_valid_m = 1'b0;
        s_keep_m  = '0;
        s_last_m  = 1'b0;
        m_ready   = 1'b1;
        m_ready_m = 1'b1;
        p_stall   = 1'b0;
        p_word    = '0;
        for (int i = 0; i < R; i++) begin
            s_data[i]   = '0;
            s_data_m[i] = '0;
        end

        fork
            forever begin
                @(posedge clk);
                #1;
                m_ready = stall_en ? 1'($urandom) : 1'b1;
            end
            forever begin
                @(negedge clk);
                if (!rst) begin
                    if (p_stall) begin
                        chk("stall_valid", {31'd0, m_valid}, 32'd1);
                        chk("stall_stable", {22'd0, m_data, m_keep, m_last},
                            {22'd0, p_word});
                    end
                    if (m_valid && m_ready) begin
                        chk("q_nonempty", {31'd0, exp_q.size() != 0}, 32'd1);
                        if (exp_q.size() != 0) begin
                            ew = exp_q.pop_front();
                            chk("word", {22'd0, m_data, m_keep, m_last},
                                {22'd0, ew});
                        end
                    end
                    p_stall = m_valid && !m_ready;
                    p_word  = {m_data, m_keep, m_last};
                end else begin
                    p_stall = 1'b0;
                end
            end
        join_none

        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_valid", {31'd0, m_valid}, 32'd0);
        chk("rst_last", {31'd0, m_last}, 32'd0);
        chk("rst_keep", {31'd0, m_keep}, 32'd0);
        chk("rst_data", {24'd0, m_data}, 32'd0);
        chk("rst_ready", {31'd0, s_ready}, 32'd1);
        @(posedge clk);
        #1;

        // Full beat, ascending order, one word per cycle.
        d[0] = 8'h11; d[1] = 8'h22; d[2] = 8'h33; d[3] = 8'h44;
        send(d, 4'b1111, 1'b1);
        s_valid = 1'b0;
        for (int i = 0; i < R; i++) begin
            @(negedge clk);
            chk("full_valid", {31'd0, m_valid}, 32'd1);
            chk("full_data", {24'd0, m_data}, 32'h11 * (i + 1));
            chk("full_last", {31'd0, m_last}, {31'd0, i == R - 1});
        end
        @(negedge clk);
        chk("full_idle", {31'd0, m_valid}, 32'd0);
        @(posedge clk);
        #1;

        // Sparse keep: non-kept words never appear.
        d[0] = 8'hA0; d[1] = 8'hB1; d[2] = 8'hC2; d[3] = 8'hD3;
        send(d, 4'b0101, 1'b1);
        s_valid = 1'b0;
        @(negedge clk);
        chk("sparse_d0", {24'd0, m_data}, 32'hA0);
        chk("sparse_l0", {31'd0, m_last}, 32'd0);
        @(negedge clk);
        chk("sparse_d2", {24'd0, m_data}, 32'hC2);
        chk("sparse_l2", {31'd0, m_last}, 32'd1);
        @(negedge clk);
        chk("sparse_idle", {31'd0, m_valid}, 32'd0);
        @(posedge clk);
        #1;

        // Empty beat dropped, empty last beat gives a null terminator.
        send(d, 4'b0000, 1'b0);
        s_valid = 1'b0;
        @(negedge clk);
        chk("drop_valid", {31'd0, m_valid}, 32'd0);
        @(posedge clk);
        #1;
        send(d, 4'b0000, 1'b1);
        s_valid = 1'b0;
        @(negedge clk);
        chk("null_valid", {31'd0, m_valid}, 32'd1);
        chk("null_word", {22'd0, m_data, m_keep, m_last}, 32'h001);
        @(negedge clk);
        chk("null_idle", {31'd0, m_valid}, 32'd0);
        @(posedge clk);
        #1;

        // Descending order, two back-to-back beats.
        for (int i = 0; i < R; i++) begin
            d[i] = 8'h10 + 8'(i);
            e[i] = 8'h50 + 8'(i);
        end
        s_data_m  = d;
        s_keep_m  = 4'b1111;
        s_last_m  = 1'b1;
        s_valid_m = 1'b1;
        @(negedge clk);
        chk("msb_ready0", {31'd0, s_ready_m}, 32'd1);
        @(posedge clk);
        #1;
        s_data_m = e;
        for (int i = 0; i < 2 * R; i++) begin
            @(negedge clk);
            chk("msb_valid", {31'd0, m_valid_m}, 32'd1);
            chk("msb_data", {24'd0, m_data_m},
                (i < R) ? {24'd0, d[R-1-i]} : {24'd0, e[2*R-1-i]});
            chk("msb_last", {31'd0, m_last_m}, {31'd0, i == R - 1 || i == 2 * R - 1});
            if (i == R - 1) begin
                chk("msb_ready_final", {31'd0, s_ready_m}, 32'd1);
                @(posedge clk);
                #1;
                s_valid_m = 1'b0;
            end
        end
        @(negedge clk);
        chk("msb_idle", {31'd0, m_valid_m}, 32'd0);
        @(posedge clk);
        #1;

        // Reset after the second of four words.
        for (int i = 0; i < R; i++) d[i] = 8'($urandom);
        send(d, 4'b1111, 1'b1);
        s_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_q.delete();
        @(negedge clk);
        chk("midrst_valid", {31'd0, m_valid}, 32'd0);
        chk("midrst_ready", {31'd0, s_ready}, 32'd1);
        @(posedge clk);
        #1;
        for (int i = 0; i < R; i++) d[i] = 8'($urandom);
        send(d, 4'b1110, 1'b1);
        s_valid = 1'b0;
        @(negedge clk);
        chk("midrst_first", {24'd0, m_data}, {24'd0, d[1]});
        repeat (4) @(negedge clk);
        chk("midrst_drain", exp_q.size(), 32'd0);
        @(posedge clk);
        #1;

        // Random beats under random output stalls.
        stall_en = 1'b1;
        for (int b = 0; b < 1000; b++) begin
            for (int i = 0; i < R; i++) d[i] = 8'($urandom);
            send(d, 4'($urandom), 1'($urandom));
            if ($urandom_range(0, 3) == 0) begin
                s_valid = 1'b0;
                @(posedge clk);
                #1;
            end
        end
        s_valid = 1'b0;
        n = 0;
        while (exp_q.size() != 0 && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk("rand_drain", exp_q.size(), 32'd0);
        stall_en = 1'b0;
        repeat (2) @(posedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
